modexp_engine: RTL and testbench

Parametrised modular-exponentiation engine computing C = M^E mod P with square-and-multiply and an interleaved shift-add modular multiplier. It needs no precomputed Montgomery constant. It replaces the fixed 7-bit exponentiation unit behind the SPI register bank. It adds operand-width scaling, a start/busy/done/abort handshake and operand validation with an error flag. The register-bank top drives its operands and maps busy/done/err into the status register.

---
 rtl/modexp_pkg.sv | 14 +
 rtl/modexp_modmul.sv | 55 +++++
 rtl/modexp_engine.sv | 131 +++++++++++++
 tb/tb_modexp_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation engine.
package modexp_pkg;

  localparam int MODEXP_MIN_WIDTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SQR,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/modexp_modmul.sv
// Interleaved shift-add modular multiplier: r = a*b mod p, MSB-first over b.
// One launch cycle (go) followed by WIDTH iteration cycles; r is valid while rdy is high.
module modexp_modmul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             rdy,
  output logic [WIDTH-1:0] r
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_reg, b_reg, p_reg, r_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   dbl_raw, sum_raw;
  logic [WIDTH-1:0] dbl_red, r_next;

  // Both operands are below p, so every intermediate fits in WIDTH+1 bits.
  always_comb begin
    dbl_raw = {r_reg, 1'b0};
    dbl_red = (dbl_raw >= {1'b0, p_reg}) ? WIDTH'(dbl_raw - {1'b0, p_reg}) : dbl_raw[WIDTH-1:0];
    sum_raw = {1'b0, dbl_red} + (b_reg[WIDTH-1] ? {1'b0, a_reg} : '0);
    r_next  = (sum_raw >= {1'b0, p_reg}) ? WIDTH'(sum_raw - {1'b0, p_reg}) : sum_raw[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      p_reg   <= '0;
      r_reg   <= '0;
      cnt_reg <= '0;
    end else if (go) begin
      a_reg   <= a;
      b_reg   <= b;
      p_reg   <= p;
      r_reg   <= '0;
      cnt_reg <= CNT_W'(WIDTH);
    end else if (cnt_reg != '0) begin
      r_reg   <= r_next;
      b_reg   <= {b_reg[WIDTH-2:0], 1'b0};
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // A relaunch masks any count left over from an aborted multiplication.
  assign rdy = !go && (cnt_reg == CNT_W'(1));
  assign r   = r_next;

endmodule

// File: rtl/modexp_engine.sv
// Square-and-multiply modular exponentiation C = M^E mod P with start/busy/done/abort.
// Define MODEXP_CONST_TIME_EN to run a (possibly discarded) multiply for every exponent bit.
module modexp_engine
  import modexp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] c
);

  localparam int IDX_W = $clog2(WIDTH);

`ifdef MODEXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  if (WIDTH < MODEXP_MIN_WIDTH) begin : g_width_check
    $error("modexp_engine: WIDTH must be at least 2");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] p_reg, e_reg, m_reg, acc_reg, acc_next, c_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             err_reg, go_reg;
  logic             operand_bad, last_bit;
  logic [WIDTH-1:0] mul_b, mul_r;
  logic             mul_rdy;

  modexp_modmul #(
    .WIDTH(WIDTH)
  ) u_modmul (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go_reg),
    .a    (acc_reg),
    .b    (mul_b),
    .p    (p_reg),
    .rdy  (mul_rdy),
    .r    (mul_r)
  );

  assign operand_bad = (p_reg < WIDTH'(2)) || (m_reg >= p_reg);
  assign last_bit    = (idx_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start && !abort) state_next = CHECK;
      CHECK: state_next = operand_bad ? DONE : SQR;
      SQR: begin
        if (mul_rdy) begin
          if (CONST_TIME || e_reg[idx_reg]) state_next = MUL;
          else if (last_bit)                state_next = DONE;
          else                              state_next = SQR;
        end
      end
      MUL:   if (mul_rdy) state_next = last_bit ? DONE : SQR;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) state_next = IDLE;
  end

  always_comb begin
    busy  = (state_reg != IDLE);
    done  = (state_reg == DONE);
    err   = err_reg;
    c     = c_reg;
    mul_b = (state_reg == MUL) ? m_reg : acc_reg;
  end

  // A MUL on a clear exponent bit only happens in the constant-time build; its product is dropped.
  always_comb begin
    acc_next = acc_reg;
    if (mul_rdy) begin
      if (state_reg == SQR)                       acc_next = mul_r;
      else if (state_reg == MUL && e_reg[idx_reg]) acc_next = mul_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg   <= '0;
      e_reg   <= '0;
      m_reg   <= '0;
      acc_reg <= '0;
      c_reg   <= '0;
      idx_reg <= '0;
      err_reg <= 1'b0;
      go_reg  <= 1'b0;
    end else begin
      go_reg <= (state_next == SQR || state_next == MUL) && (state_reg == CHECK || mul_rdy);
      if (state_reg == IDLE && start && !abort) begin
        p_reg   <= p;
        e_reg   <= e;
        m_reg   <= m;
        err_reg <= 1'b0;
      end
      if (state_reg == CHECK) begin
        acc_reg <= WIDTH'(1);
        idx_reg <= IDX_W'(WIDTH - 1);
        if (operand_bad) begin
          err_reg <= 1'b1;
          c_reg   <= '0;
        end
      end else begin
        acc_reg <= acc_next;
      end
      if (mul_rdy && state_next == SQR) idx_reg <= idx_reg - IDX_W'(1);
      if (mul_rdy && state_next == DONE) c_reg <= acc_next;
    end
  end

endmodule

// File: tb/tb_modexp_engine.sv
// Self-checking bench for modexp_engine: directed table, random vectors against a
// right-to-left exponentiation model, and handshake/reset sequences.
module tb_modexp_engine;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [W-1:0] p = '0, e = '0, m = '0;
  logic busy, done, err;
  logic [W-1:0] c;

  logic start16 = 1'b0, abort16 = 1'b0;
  logic [15:0] p16 = '0, e16 = '0, m16 = '0;
  logic busy16, done16, err16;
  logic [15:0] c16;

  int checks = 0;
  int failures = 0;

  modexp_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .p(p), .e(e), .m(m), .busy(busy), .done(done), .err(err), .c(c)
  );

  modexp_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16),
    .p(p16), .e(e16), .m(m16), .busy(busy16), .done(done16), .err(err16), .c(c16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] c;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic longint unsigned ref_pow(longint unsigned base, longint unsigned ex,
                                              longint unsigned md);
    longint unsigned res = 1 % md;
    longint unsigned b = base % md;
    while (ex != 0) begin
      if (ex[0]) res = (res * b) % md;
      b = (b * b) % md;
      ex = ex >> 1;
    end
    return res;
  endfunction

  function automatic int ref_lat(int w, logic [63:0] ev, bit bad);
    if (bad) return 2;
`ifdef MODEXP_CONST_TIME_EN
    return 2 + 2 * w * (w + 1);
`else
    return 2 + (w + 1) * (w + $countones(ev));
`endif
  endfunction

  // Launches one operation, scrambles the inputs after the start edge and waits for done.
  task automatic run_op(input logic [W-1:0] tp, input logic [W-1:0] te, input logic [W-1:0] tm,
                        input int stray_at, output logic [W-1:0] rc, output logic rerr,
                        output int lat);
    @(negedge clk);
    p = tp; e = te; m = tm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    p = W'($urandom); e = W'($urandom); m = W'($urandom);
    lat = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_start", busy, 1);
      start = (k == stray_at);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    rc = c;
    rerr = err;
  endtask

  initial begin
    vec_t vecs[8];
    logic [W-1:0] rc, tp, te, tm;
    logic rerr, bad;
    int lat, seen;

    vecs[0] = '{p: 8'hFB, e: 8'h0A, m: 8'h02, c: 8'h14, err: 1'b0};
    vecs[1] = '{p: 8'd33, e: 8'd7,  m: 8'd2,  c: 8'd29, err: 1'b0};
    vecs[2] = '{p: 8'd33, e: 8'd3,  m: 8'd29, c: 8'd2,  err: 1'b0};
    vecs[3] = '{p: 8'h01, e: 8'h05, m: 8'h00, c: 8'h00, err: 1'b1};
    vecs[4] = '{p: 8'h40, e: 8'h05, m: 8'h40, c: 8'h00, err: 1'b1};
    vecs[5] = '{p: 8'h0D, e: 8'h00, m: 8'h05, c: 8'h01, err: 1'b0};
    vecs[6] = '{p: 8'h0D, e: 8'h03, m: 8'h00, c: 8'h00, err: 1'b0};
    vecs[7] = '{p: 8'hFB, e: 8'hFF, m: 8'hFA, c: 8'hFA, err: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_c", c, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].p, vecs[i].e, vecs[i].m, -1, rc, rerr, lat);
      $display("vec %0d p=%0h e=%0h m=%0h -> c=%0h err=%0b lat=%0d", i, vecs[i].p, vecs[i].e,
               vecs[i].m, rc, rerr, lat);
      check($sformatf("vec%0d_c", i), rc, vecs[i].c);
      check($sformatf("vec%0d_err", i), rerr, vecs[i].err);
      check($sformatf("vec%0d_lat", i), lat, ref_lat(W, vecs[i].e, vecs[i].err));
    end

    for (int i = 0; i < 30; i++) begin
      tp = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(2, 255));
      tm = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom % ((tp < 2) ? 2 : tp));
      te = W'($urandom);
      bad = (tp < 2) || (tm >= tp);
      run_op(tp, te, tm, -1, rc, rerr, lat);
      $display("rnd %0d p=%0h e=%0h m=%0h -> c=%0h err=%0b lat=%0d", i, tp, te, tm, rc, rerr, lat);
      check($sformatf("rnd%0d_c", i), rc, bad ? 0 : ref_pow(tm, te, tp));
      check($sformatf("rnd%0d_err", i), rerr, bad);
      check($sformatf("rnd%0d_lat", i), lat, ref_lat(W, te, bad));
    end

    // Stray start mid-operation must be ignored.
    run_op(8'hFB, 8'h0A, 8'h02, 30, rc, rerr, lat);
    $display("stray_start c=%0h lat=%0d", rc, lat);
    check("stray_c", rc, 8'h14);
    check("stray_lat", lat, ref_lat(W, 8'h0A, 1'b0));
    repeat (4) @(negedge clk);
    check("stray_no_second_op", busy, 0);

    // Abort at cycle 20.
    @(negedge clk);
    p = 8'd33; e = 8'd7; m = 8'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    $display("abort seen_activity=%0d c=%0h", seen, c);
    check("abort_no_done", seen, 0);
    check("abort_c_held", c, 8'h14);

    // start and abort together in IDLE.
    @(negedge clk);
    p = 8'd33; e = 8'd7; m = 8'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    $display("start_abort seen_activity=%0d c=%0h", seen, c);
    check("start_abort_idle", seen, 0);
    check("start_abort_c", c, 8'h14);

    // Asynchronous reset mid-SQR.
    @(negedge clk);
    p = 8'd33; e = 8'd7; m = 8'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("mid_reset busy=%0b done=%0b err=%0b c=%0h", busy, done, err, c);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_c", c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd33, 8'd7, 8'd2, -1, rc, rerr, lat);
    $display("post_reset c=%0h err=%0b lat=%0d", rc, rerr, lat);
    check("post_rst_c", rc, 8'd29);
    check("post_rst_lat", lat, ref_lat(W, 8'd7, 1'b0));

    // WIDTH=16 instance.
    @(negedge clk);
    p16 = 16'hFFF1; e16 = 16'h0002; m16 = 16'hFFF0; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (done16) begin
        lat = k;
        break;
      end
    end
    $display("w16 c=%0h err=%0b lat=%0d", c16, err16, lat);
    check("w16_c", c16, 16'h0001);
    check("w16_err", err16, 0);
    check("w16_lat", lat, ref_lat(16, 16'h0002, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
